serial_word_collector: RTL and testbench

- Downstream companion of the team's right-shift register.
- Consumes the LSB-first serial stream taken from the shift register's q[0] and reassembles DW-bit parallel words.
- Presents each completed word on a one-entry valid/ready output buffer.
- Flags words lost to back-pressure with a sticky overrun flag.

---
 rtl/serial_word_collector.sv | 158 +++++++++++++++
 tb/tb_serial_word_collector.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_collector.sv
// Reassembles an LSB-first serial bit stream into DW-bit words and presents
// each word on a one-entry valid/ready buffer with a sticky overrun flag.
module serial_word_collector #(
    parameter int DW = 4,
    parameter int CW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          async_rst_n,
    input  logic          bit_vld,
    input  logic          bit_in,
    input  logic          frame_start,
    output logic [DW-1:0] dout,
    output logic          dout_vld,
    input  logic          dout_rdy,
    output logic          overrun,
    input  logic          clr_ovr,
    output logic [CW-1:0] bit_cnt
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [CW-1:0] LAST_IDX = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);

    state_t        state_r;
    state_t        state_nxt_s;
    logic [CW-1:0] bit_cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    // Bit 0 of the shift is only ever consumed in the completing cycle, where
    // it comes straight from the word being formed, so it needs no storage.
    logic [DW-1:1] asm_r;
    logic [DW-1:1] asm_nxt_s;
    logic [DW-1:0] word_s;
    logic [DW-1:0] restart_word_s;
    logic [DW-1:0] dout_r;
    logic [DW-1:0] dout_nxt_s;
    logic          dout_vld_r;
    logic          vld_nxt_s;
    logic          overrun_r;
    logic          ovr_nxt_s;
    logic          last_s;
    logic          complete_s;
    logic          transfer_s;
    logic          load_s;
    logic          drop_s;

    assign word_s         = {bit_in, asm_r};
    assign restart_word_s = {bit_in, {(DW-1){1'b0}}};
    assign last_s         = (bit_cnt_r == LAST_IDX);
    // frame_start on the final bit turns that bit into the start of a new word.
    assign complete_s     = bit_vld & ~frame_start & last_s;
    assign transfer_s     = dout_vld_r & dout_rdy;
    assign load_s         = complete_s & (~dout_vld_r | transfer_s);
    assign drop_s         = complete_s & ~load_s;

    // Assembly FSM state register.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Assembly FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        if (frame_start) begin
            state_nxt_s = bit_vld ? COLLECT : IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bit_vld) begin
                        state_nxt_s = COLLECT;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end
                COLLECT: begin
                    if (bit_vld && last_s) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = COLLECT;
                    end
                end
                default: begin
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // Next values for the shift register, bit counter, output buffer and overrun flag.
    always_comb begin
        asm_nxt_s  = asm_r;
        cnt_nxt_s  = bit_cnt_r;
        dout_nxt_s = dout_r;
        vld_nxt_s  = dout_vld_r;
        ovr_nxt_s  = overrun_r;

        if (frame_start) begin
            asm_nxt_s = bit_vld ? restart_word_s[DW-1:1] : {(DW-1){1'b0}};
            cnt_nxt_s = bit_vld ? CNT_ONE : {CW{1'b0}};
        end else if (bit_vld) begin
            asm_nxt_s = word_s[DW-1:1];
            cnt_nxt_s = last_s ? {CW{1'b0}} : (bit_cnt_r + CNT_ONE);
        end else begin
            asm_nxt_s = asm_r;
            cnt_nxt_s = bit_cnt_r;
        end

        if (load_s) begin
            dout_nxt_s = word_s;
            vld_nxt_s  = 1'b1;
        end else if (transfer_s) begin
            dout_nxt_s = dout_r;
            vld_nxt_s  = 1'b0;
        end else begin
            dout_nxt_s = dout_r;
            vld_nxt_s  = dout_vld_r;
        end

        // A drop in the same cycle as a clear leaves the flag set.
        if (drop_s) begin
            ovr_nxt_s = 1'b1;
        end else if (clr_ovr) begin
            ovr_nxt_s = 1'b0;
        end else begin
            ovr_nxt_s = overrun_r;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge async_rst_n) begin
        if (!async_rst_n) begin
            asm_r      <= {(DW-1){1'b0}};
            bit_cnt_r  <= {CW{1'b0}};
            dout_r     <= {DW{1'b0}};
            dout_vld_r <= 1'b0;
            overrun_r  <= 1'b0;
        end else begin
            asm_r      <= asm_nxt_s;
            bit_cnt_r  <= cnt_nxt_s;
            dout_r     <= dout_nxt_s;
            dout_vld_r <= vld_nxt_s;
            overrun_r  <= ovr_nxt_s;
        end
    end

    assign dout     = dout_r;
    assign dout_vld = dout_vld_r;
    assign overrun  = overrun_r;
    assign bit_cnt  = bit_cnt_r;

endmodule

// File: tb/tb_serial_word_collector.sv
// Directed self-checking bench for serial_word_collector (DW=4) using an
// expected-word queue filled as words are sent and drained as they appear.
module tb_serial_word_collector;

    logic       clk;
    logic       async_rst_n;
    logic       bit_vld;
    logic       bit_in;
    logic       frame_start;
    logic [3:0] dout;
    logic       dout_vld;
    logic       dout_rdy;
    logic       overrun;
    logic       clr_ovr;
    logic [1:0] bit_cnt;

    int         tests;
    int         fails;
    logic [3:0] exp_q[$];

    serial_word_collector #(.DW(4)) dut (
        .clk         (clk),
        .async_rst_n (async_rst_n),
        .bit_vld     (bit_vld),
        .bit_in      (bit_in),
        .frame_start (frame_start),
        .dout        (dout),
        .dout_vld    (dout_vld),
        .dout_rdy    (dout_rdy),
        .overrun     (overrun),
        .clr_ovr     (clr_ovr),
        .bit_cnt     (bit_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pop(input string tag);
        logic [3:0] e;
        if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, dout);
        end else begin
            e = exp_q.pop_front();
            chk(tag, 32'(dout), 32'(e));
        end
    endtask

    task automatic send_bit(input logic b);
        bit_vld = 1'b1;
        bit_in  = b;
        tick();
        bit_vld = 1'b0;
        bit_in  = 1'b0;
    endtask

    task automatic send_word(input logic [3:0] w);
        for (int i = 0; i < 4; i++) send_bit(w[i]);
    endtask

    initial begin
        logic [3:0] w;
        clk = 1'b0; async_rst_n = 1'b0; bit_vld = 1'b0; bit_in = 1'b0;
        frame_start = 1'b0; dout_rdy = 1'b0; clr_ovr = 1'b0;
        tests = 0; fails = 0;

        // Reset state
        tick(); tick();
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_vld", 32'(dout_vld), 32'h0);
        chk("rst_ovr", 32'(overrun), 32'h0);
        chk("rst_cnt", 32'(bit_cnt), 32'h0);
        async_rst_n = 1'b1;
        tick();

        // Consecutive bits 1,0,1,1 -> 4'hD
        dout_rdy = 1'b1;
        send_bit(1'b1); chk("t1_cnt1", 32'(bit_cnt), 32'd1);
        chk("t1_vld_early", 32'(dout_vld), 32'h0);
        send_bit(1'b0); chk("t1_cnt2", 32'(bit_cnt), 32'd2);
        send_bit(1'b1); chk("t1_cnt3", 32'(bit_cnt), 32'd3);
        chk("t1_vld_before_last", 32'(dout_vld), 32'h0);
        exp_q.push_back(4'hD);
        send_bit(1'b1); chk("t1_cnt0", 32'(bit_cnt), 32'd0);
        chk("t1_vld", 32'(dout_vld), 32'h1);
        chk_pop("t1_dout");
        tick();
        chk("t1_vld_one_cycle", 32'(dout_vld), 32'h0);

        // Gapped bits 0,1,1,0 -> 4'h6, count holds during gaps
        w = 4'h6;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) exp_q.push_back(4'h6);
            send_bit(w[i]);
            chk("t2_cnt", 32'(bit_cnt), 32'((i + 1) % 4));
            if (i < 3) begin
                tick(); tick();
                chk("t2_cnt_hold", 32'(bit_cnt), 32'(i + 1));
                chk("t2_vld_gap", 32'(dout_vld), 32'h0);
            end
        end
        chk("t2_vld", 32'(dout_vld), 32'h1);
        chk_pop("t2_dout");
        tick();
        chk("t2_vld_drop", 32'(dout_vld), 32'h0);

        // Back-pressure: 4'h3 held, 4'hC dropped, overrun set then cleared
        dout_rdy = 1'b0;
        exp_q.push_back(4'h3);
        send_word(4'h3);
        chk("t3_vld", 32'(dout_vld), 32'h1);
        chk_pop("t3_dout");
        send_word(4'hC);
        chk("t3_dout_held", 32'(dout), 32'h3);
        chk("t3_vld_held", 32'(dout_vld), 32'h1);
        chk("t3_ovr", 32'(overrun), 32'h1);
        dout_rdy = 1'b1; tick(); dout_rdy = 1'b0;
        chk("t3_vld_xfer", 32'(dout_vld), 32'h0);
        chk("t3_dout_keep", 32'(dout), 32'h3);
        chk("t3_ovr_sticky", 32'(overrun), 32'h1);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("t3_ovr_clr", 32'(overrun), 32'h0);

        // Completion of 4'hA coincides with transfer of pending 4'h5
        exp_q.push_back(4'h5);
        send_word(4'h5);
        chk("t4_vld5", 32'(dout_vld), 32'h1);
        chk_pop("t4_dout5");
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        dout_rdy = 1'b1;
        exp_q.push_back(4'hA);
        send_bit(1'b1);
        chk("t4_vld_stay", 32'(dout_vld), 32'h1);
        chk_pop("t4_doutA");
        chk("t4_ovr", 32'(overrun), 32'h0);
        tick();
        chk("t4_vld_drain", 32'(dout_vld), 32'h0);

        // frame_start with a bit aborts a two-bit partial word -> 4'h7
        send_bit(1'b1); send_bit(1'b0);
        frame_start = 1'b1; send_bit(1'b1); frame_start = 1'b0;
        chk("t5_cnt_restart", 32'(bit_cnt), 32'd1);
        chk("t5_vld_none", 32'(dout_vld), 32'h0);
        send_bit(1'b1); send_bit(1'b1);
        exp_q.push_back(4'h7);
        send_bit(1'b0);
        chk("t5_vld", 32'(dout_vld), 32'h1);
        chk_pop("t5_dout");
        chk("t5_ovr", 32'(overrun), 32'h0);
        tick();

        // frame_start on the 4th bit suppresses completion -> next word 4'h2
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        frame_start = 1'b1; send_bit(1'b0); frame_start = 1'b0;
        chk("t5b_cnt", 32'(bit_cnt), 32'd1);
        chk("t5b_vld_none", 32'(dout_vld), 32'h0);
        chk("t5b_ovr", 32'(overrun), 32'h0);
        send_bit(1'b1); send_bit(1'b0);
        exp_q.push_back(4'h2);
        send_bit(1'b0);
        chk("t5b_vld", 32'(dout_vld), 32'h1);
        chk_pop("t5b_dout");
        tick();

        // A drop in the same cycle as clr_ovr leaves overrun set
        dout_rdy = 1'b0;
        exp_q.push_back(4'h9);
        send_word(4'h9);
        chk_pop("t6_dout9");
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        clr_ovr = 1'b1; send_bit(1'b1); clr_ovr = 1'b0;
        chk("t6_ovr_wins", 32'(overrun), 32'h1);
        chk("t6_dout_held", 32'(dout), 32'h9);
        clr_ovr = 1'b1; tick(); clr_ovr = 1'b0;
        chk("t6_ovr_clr", 32'(overrun), 32'h0);
        dout_rdy = 1'b1; tick();
        chk("t6_vld_drain", 32'(dout_vld), 32'h0);

        // Asynchronous reset mid-word with a pending word
        dout_rdy = 1'b0;
        send_word(4'h1);
        chk("t7_pending", 32'(dout_vld), 32'h1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("t7_cnt3", 32'(bit_cnt), 32'd3);
        async_rst_n = 1'b0;
        #1;
        chk("t7_rst_dout", 32'(dout), 32'h0);
        chk("t7_rst_vld", 32'(dout_vld), 32'h0);
        chk("t7_rst_ovr", 32'(overrun), 32'h0);
        chk("t7_rst_cnt", 32'(bit_cnt), 32'h0);
        exp_q.delete();
        @(negedge clk);
        async_rst_n = 1'b1;
        tick();
        chk("t7_no_emit", 32'(dout_vld), 32'h0);
        dout_rdy = 1'b1;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        exp_q.push_back(4'h8);
        send_bit(1'b1);
        chk("t7_vld", 32'(dout_vld), 32'h1);
        chk_pop("t7_dout");
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
